// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
// Shared constants for the execute-stage controller. It holds the ALU
// operation codes, the main-control class codes, the M-extension
// funct7/funct3 codes and the MDU FSM state type.
// It also provides a helper that maps a base funct3 to its ALU code.
package alu_ctrl_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    // main-control instruction classes
    localparam logic [2:0] CLS_R     = 3'b000;
    localparam logic [2:0] CLS_I     = 3'b001;
    localparam logic [2:0] CLS_LUI   = 3'b010;
    localparam logic [2:0] CLS_BR    = 3'b011;
    localparam logic [2:0] CLS_LS    = 3'b100;
    localparam logic [2:0] CLS_AUIPC = 3'b101;
    localparam logic [2:0] CLS_JAL   = 3'b110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_M    = 7'b0000001;

    // M-extension funct3
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mdu_state_e;

    // This is the base funct3 map shared by R and I-arith.
    // Here 101 is the logical shift; SRA/SRAI are chosen by funct7.
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_mdu_control_if.sv
// alu_mdu_control_if
// This interface carries the execute-stage signals between the core (master) and alu_mdu_control (slave).
//   inputs : valid_i, alu_op_i, funct7_i, funct3_i, rs1_data_i, rs2_data_i
//   outputs: alu_operation_o, use_mdu_o, stall_o, mdu_done_o, mdu_result_o, illegal_o
interface alu_mdu_control_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [2:0]      alu_op_i;
    logic [6:0]      funct7_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [3:0]      alu_operation_o;
    logic            use_mdu_o;
    logic            stall_o;
    logic            mdu_done_o;
    logic [XLEN-1:0] mdu_result_o;
    logic            illegal_o;

    modport master (
        output valid_i, alu_op_i, funct7_i, funct3_i, rs1_data_i, rs2_data_i,
        input  alu_operation_o, use_mdu_o, stall_o, mdu_done_o, mdu_result_o, illegal_o
    );

    modport slave (
        input  valid_i, alu_op_i, funct7_i, funct3_i, rs1_data_i, rs2_data_i,
        output alu_operation_o, use_mdu_o, stall_o, mdu_done_o, mdu_result_o, illegal_o
    );
endinterface

// File: rtl/mdu_iter_core.sv
// mdu_iter_core
// This is the iterative multiply/divide datapath. It uses a radix-2 shift-add multiplier
// and a restoring divider, which share one 2*XLEN accumulator.
//   accept : load operand magnitudes and sign flags, or load the special-case result
//   step   : run one radix-2 iteration
//   last   : this step is the final one, so write the sign-corrected result
//   special: the divide-by-zero or signed-overflow case, finished without iterating
//   result : registered M-extension result
module mdu_iter_core
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            accept,
    input  logic            step,
    input  logic            last,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            special,
    output logic [XLEN-1:0] result
);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic            s1_signed, s2_signed, neg1, neg2, div_zero, div_ovf;
    logic [XLEN-1:0] mag1, mag2, special_res;
    logic [2:0]      op_r;
    logic            neg_r, dsign_r;
    logic [XLEN-1:0] b_r;
    logic [2*XLEN-1:0] acc, acc_nxt, prod_fix;
    logic [XLEN:0]   rem_sh, diff, sum;
    logic [XLEN-1:0] q_fix, r_fix, final_res;

    // Operand preparation works on the live inputs during the accept cycle.
    always_comb begin
        s1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
        s2_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        neg1      = s1_signed && rs1[XLEN-1];
        neg2      = s2_signed && rs2[XLEN-1];
        mag1      = neg1 ? -rs1 : rs1;
        mag2      = neg2 ? -rs2 : rs2;
        div_zero  = funct3[2] && (rs2 == '0);
        div_ovf   = funct3[2] && s2_signed && (rs1 == MIN) && (rs2 == '1);
        special   = div_zero || div_ovf;
        // In funct3, bit 1 separates REM/REMU from DIV/DIVU.
        if (div_zero) special_res = funct3[1] ? rs1 : '1;
        else          special_res = funct3[1] ? '0 : MIN;
    end

    // The accumulator layout is {hi, lo}.
    // For a multiply, hi holds the partial product and lo holds the remaining multiplier bits.
    // For a divide, hi holds the remainder and lo holds the dividend bits shifting into the quotient.
    always_comb begin
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, b_r};
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_r} : '0);
        if (op_r[2])
            acc_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};
        else
            acc_nxt = {sum, acc[XLEN-1:1]};
        prod_fix = neg_r   ? -acc_nxt : acc_nxt;
        q_fix    = neg_r   ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        r_fix    = dsign_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_r)
            F3_MUL:                        final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = q_fix;
            default:                       final_res = r_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r    <= '0;
            neg_r   <= 1'b0;
            dsign_r <= 1'b0;
            b_r     <= '0;
            acc     <= '0;
            result  <= '0;
        end else if (accept) begin
            op_r    <= funct3;
            neg_r   <= neg1 ^ neg2;
            dsign_r <= neg1;
            b_r     <= mag2;
            acc     <= {{XLEN{1'b0}}, mag1};
            if (special) result <= special_res;
        end else if (step) begin
            acc <= acc_nxt;
            if (last) result <= final_res;
        end
    end
endmodule

// File: rtl/alu_mdu_control.sv
// alu_mdu_control
// This is the execute-stage controller. It decodes alu_op/funct7/funct3 into the ALU
// operation code and sequences M-extension instructions through mdu_iter_core.
// While an M instruction is in flight, it stalls the core.
//   clk, reset : clock, async active-high reset
//   bus        : alu_mdu_control_if.slave (instruction fields, operands, results)
module alu_mdu_control
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input logic              clk,
    input logic              reset,
    alu_mdu_control_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    mdu_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0]    alu_op;
    logic          m_op, illegal, use_mdu, accept, step, last, special;

    // decoder
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        m_op    = 1'b0;
        case (bus.alu_op_i)
            CLS_R: begin
                if (bus.funct7_i == F7_BASE)                             alu_op = base_op(bus.funct3_i);
                else if (bus.funct7_i == F7_ALT && bus.funct3_i == 3'b000) alu_op = ALU_SUB;
                else if (bus.funct7_i == F7_ALT && bus.funct3_i == 3'b101) alu_op = ALU_SRA;
                else if (bus.funct7_i == F7_M) begin
                    m_op    = 1'b1;
                    illegal = !ENABLE_M;
                end else                                                   illegal = 1'b1;
            end
            // In I-arith, funct7 is immediate bits except for the SRAI marker bit.
            CLS_I:   alu_op = (bus.funct3_i == 3'b101 && bus.funct7_i[5]) ? ALU_SRA
                                                                          : base_op(bus.funct3_i);
            CLS_LUI: alu_op = ALU_PASSB;
            CLS_BR:  alu_op = ALU_SUB;
            CLS_LS, CLS_AUIPC, CLS_JAL: alu_op = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

    assign use_mdu = m_op && ENABLE_M;
    assign accept  = (state == S_IDLE) && bus.valid_i && use_mdu;
    assign step    = (state == S_BUSY) && bus.valid_i;
    assign last    = (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)    cnt <= '0;
            else if (step) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = special ? S_DONE : S_BUSY;
            // Dropping valid_i (a flush) abandons the operation without a done pulse.
            S_BUSY:  if (!bus.valid_i) state_nxt = S_IDLE;
                     else if (last)    state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.alu_operation_o = alu_op;
        bus.use_mdu_o       = use_mdu;
        bus.illegal_o       = illegal;
        bus.mdu_done_o      = (state == S_DONE);
        bus.stall_o         = bus.valid_i && use_mdu && (state != S_DONE);
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .step    (step),
        .last    (last),
        .funct3  (bus.funct3_i),
        .rs1     (bus.rs1_data_i),
        .rs2     (bus.rs2_data_i),
        .special (special),
        .result  (bus.mdu_result_o)
    );
endmodule

// File: tb/tb_alu_mdu_control.sv
// tb_alu_mdu_control
// This is the self-checking bench for alu_mdu_control at XLEN=32. It includes a second
// instance with ENABLE_M=0 that shares the same stimulus. Every output is compared on each
// negedge against a behavioural model: 64-bit arithmetic for results and a cycle countdown
// for timing. Directed cases pin the model to literal values.
module tb_alu_mdu_control;
    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_mdu_control_if #(.XLEN(XLEN)) bus ();
    alu_mdu_control_if #(.XLEN(XLEN)) bus0 ();

    alu_mdu_control #(.XLEN(XLEN), .ENABLE_M(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus));
    alu_mdu_control #(.XLEN(XLEN), .ENABLE_M(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    assign bus0.valid_i    = bus.valid_i;
    assign bus0.alu_op_i   = bus.alu_op_i;
    assign bus0.funct7_i   = bus.funct7_i;
    assign bus0.funct3_i   = bus.funct3_i;
    assign bus0.rs1_data_i = bus.rs1_data_i;
    assign bus0.rs2_data_i = bus.rs2_data_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference arithmetic
    function automatic logic [31:0] m_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return MINV;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic logic m_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF));
    endfunction

    // reference decode
    function automatic void dec_ref(input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                    output logic [3:0] alu, output logic use_m, output logic ill);
        logic [3:0] tab [8] = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
        alu = 4'h0; use_m = 1'b0; ill = 1'b0;
        case (op)
            3'd0: if (f7 == 7'h01) use_m = 1'b1;
                  else if (f7 == 7'h00) alu = tab[f3];
                  else if (f7 == 7'h20 && f3 == 3'd0) alu = 4'h1;
                  else if (f7 == 7'h20 && f3 == 3'd5) alu = 4'h7;
                  else ill = 1'b1;
            3'd1: alu = (f3 == 3'd5 && f7[5]) ? 4'h7 : tab[f3];
            3'd2: alu = 4'hA;
            3'd3: alu = 4'h1;
            3'd4, 3'd5, 3'd6: alu = 4'h0;
            default: ill = 1'b1;
        endcase
    endfunction

    // cycle model and per-cycle compare
    bit          m_done = 1'b0;
    int          busy_left = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(negedge clk) begin
        logic [3:0] e_alu;
        logic e_use, e_ill, e_stall;
        dec_ref(bus.alu_op_i, bus.funct7_i, bus.funct3_i, e_alu, e_use, e_ill);
        if (reset) begin
            m_done = 1'b0; busy_left = 0; m_res = '0;
        end
        e_stall = bus.valid_i && e_use && !m_done;
        if (!e_use) chk("alu_operation", bus.alu_operation_o, e_alu);
        chk("use_mdu", bus.use_mdu_o, e_use);
        chk("illegal", bus.illegal_o, e_ill);
        chk("stall", bus.stall_o, e_stall);
        chk("mdu_done", bus.mdu_done_o, m_done);
        chk("mdu_result", bus.mdu_result_o, m_res);
        chk("nom_alu", bus0.alu_operation_o, e_alu);
        chk("nom_illegal", bus0.illegal_o, e_ill | e_use);
        chk("nom_stall", bus0.stall_o, 1'b0);
        chk("nom_done", bus0.mdu_done_o, 1'b0);
        chk("nom_result", bus0.mdu_result_o, 32'h0);
        if (!reset) begin
            if (m_done) m_done = 1'b0;
            else if (busy_left > 0) begin
                if (!bus.valid_i) busy_left = 0;
                else begin
                    busy_left--;
                    if (busy_left == 0) begin m_done = 1'b1; m_res = m_pend; end
                end
            end else if (bus.valid_i && e_use) begin
                m_pend = m_ref(bus.funct3_i, bus.rs1_data_i, bus.rs2_data_i);
                if (m_special(bus.funct3_i, bus.rs1_data_i, bus.rs2_data_i)) begin
                    m_done = 1'b1; m_res = m_pend;
                end else busy_left = XLEN;
            end
        end
    end

    // stimulus
    task automatic drive(input logic v, input logic [2:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.valid_i = v; bus.alu_op_i = op; bus.funct7_i = f7; bus.funct3_i = f3;
        bus.rs1_data_i = a; bus.rs2_data_i = b;
    endtask

    // Present an M op and watch it. If abort_at>0, valid drops during that cycle.
    task automatic run_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int abort_at,
                         output int lat, output int stalls, output bit seen, output logic [31:0] res);
        drive(1'b1, 3'd0, 7'h01, f3, a, b);
        lat = -1; stalls = 0; seen = 1'b0; res = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.stall_o) stalls++;
            if (bus.mdu_done_o) begin seen = 1'b1; lat = c; res = bus.mdu_result_o; break; end
            if (abort_at > 0 && c == abort_at - 1) begin @(posedge clk); #1 bus.valid_i = 1'b0; end
        end
        if (abort_at <= 0) begin
            chk("m_done_seen", seen, 1'b1);
            if (seen) chk("m_value", res, m_ref(f3, a, b));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat, st;
        bit seen;
        logic [31:0] res, a, b;
        logic [2:0] f3, op;
        logic [6:0] f7;
        int ab;

        bus.valid_i = 1'b0; bus.alu_op_i = '0; bus.funct7_i = '0; bus.funct3_i = '0;
        bus.rs1_data_i = '0; bus.rs2_data_i = '0;
        @(negedge clk);
        chk("reset_result", bus.mdu_result_o, 32'h0);
        chk("reset_done", bus.mdu_done_o, 1'b0);
        chk("reset_stall", bus.stall_o, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        run_m(3'd0, 32'd7, 32'hFFFF_FFFD, 0, lat, st, seen, res);
        chk("mul_lat", lat, 33); chk("mul_stalls", st, 33); chk("mul_res", res, 32'hFFFF_FFEB);
        run_m(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, st, seen, res);
        chk("mulhu_res", res, 32'hFFFF_FFFE);
        run_m(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, st, seen, res);
        chk("mulh_res", res, 32'h0);
        run_m(3'd4, MINV, 32'hFFFF_FFFF, 0, lat, st, seen, res);
        chk("div_ovf_lat", lat, 1); chk("div_ovf_stalls", st, 1); chk("div_ovf_res", res, MINV);
        run_m(3'd6, MINV, 32'hFFFF_FFFF, 0, lat, st, seen, res);
        chk("rem_ovf_res", res, 32'h0);
        run_m(3'd5, 32'd100, 32'd0, 0, lat, st, seen, res);
        chk("divu0_lat", lat, 1); chk("divu0_res", res, 32'hFFFF_FFFF);
        run_m(3'd7, 32'd100, 32'd0, 0, lat, st, seen, res);
        chk("remu0_res", res, 32'd100);
        run_m(3'd4, -32'sd7, 32'd2, 0, lat, st, seen, res);
        chk("div_neg_lat", lat, 33); chk("div_neg_res", res, 32'hFFFF_FFFD);
        run_m(3'd6, -32'sd7, 32'd2, 0, lat, st, seen, res);
        chk("rem_neg_res", res, 32'hFFFF_FFFF);

        drive(1'b1, 3'd0, 7'h20, 3'd0, 32'd5, 32'd3);
        @(negedge clk); chk("r_sub_op", bus.alu_operation_o, 4'b0001); chk("r_sub_stall", bus.stall_o, 1'b0);
        drive(1'b1, 3'd2, 7'h00, 3'd0, 32'd0, 32'd0);
        @(negedge clk); chk("lui_op", bus.alu_operation_o, 4'b1010);
        drive(1'b1, 3'd0, 7'h02, 3'd0, 32'd0, 32'd0);
        @(negedge clk); chk("r_bad_f7_illegal", bus.illegal_o, 1'b1);

        // abort: DIVU flushed at cycle 10, no done pulse, result keeps REM value
        run_m(3'd5, 32'd1000, 32'd7, 10, lat, st, seen, res);
        chk("abort_no_done", seen, 1'b0);
        chk("abort_result_kept", bus.mdu_result_o, 32'hFFFF_FFFF);

        // reset at cycle 5 of a MUL
        drive(1'b1, 3'd0, 7'h01, 3'd0, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1; bus.valid_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_result", bus.mdu_result_o, 32'h0);
        chk("rst_mid_done", bus.mdu_done_o, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        run_m(3'd0, 32'd6, 32'd7, 0, lat, st, seen, res);
        chk("post_rst_lat", lat, 33); chk("post_rst_res", res, 32'd42);

        // random mix
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                op = 3'($urandom_range(0, 7));
                f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
                if (op == 3'd0 && f7 == 7'h01) f7 = 7'h00;
                drive(1'($urandom_range(0, 1)), op, f7, 3'($urandom), $urandom, $urandom);
            end else begin
                f3 = 3'($urandom);
                a = pick(); b = pick();
                ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 30) : 0;
                run_m(f3, a, b, ab, lat, st, seen, res);
                if (ab == 0) chk("rand_lat", lat, m_special(f3, a, b) ? 1 : 33);
                else if (!m_special(f3, a, b)) chk("rand_abort_no_done", seen, 1'b0);
            end
        end

        drive(1'b0, 3'd0, 7'h00, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu_control.md
# alu_mdu_control

Parametrised execute-stage controller replacing the combinational ALU decoder. Decodes ALU_Op/funct7/funct3 into the 4-bit ALU operation code for base RV32I/RV64I instructions, and adds the M extension: an iterative shift-add multiplier and restoring divider. While an M instruction is in flight, the block stalls the single-cycle core's PC/register-file write. Sits between the main control unit, the register file read ports and the writeback mux.

## Interface
- XLEN, 32: operand/result width; any value ≥ 4.
- ENABLE_M, 1: 1 enables the MDU; 0 makes M encodings raise illegal_o.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  instruction in execute is valid; low = flush/bubble.
- alu_op_i  in  3  main-control class: 000 R, 001 I-arith, 010 LUI, 011 branch, 100 load/store, 101 AUIPC, 110 JAL/JALR.
- funct7_i  in  7  instruction [31:25].
- funct3_i  in  3  instruction [14:12].
- rs1_data_i, rs2_data_i  in  XLEN  operands.
- alu_operation_o  out  4  ALU op code (combinational).
- use_mdu_o  out  1  writeback selects mdu_result_o (combinational).
- stall_o  out  1  hold PC and suppress register write (combinational).
- mdu_done_o  out  1  mdu_result_o valid this cycle (registered state).
- mdu_result_o  out  XLEN  M-extension result.
- illegal_o  out  1  unsupported encoding (combinational).

## Operation
- ALU codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSB 1010.
- Decode rules:
  - R: funct7=0000000 → by funct3; funct7=0100000 → SUB (f3 000) or SRA (f3 101).
  - I-arith: as R, except SUB is never selected; SRAI needs funct7[5]=1.
  - LUI → PASSB. Branch → SUB. Load/store, AUIPC, JAL/JALR → ADD.
  - Any other combination → ADD with illegal_o=1.
- M op: alu_op_i=000 and funct7=0000001. funct3 values: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - use_mdu_o=1 for an M op; alu_operation_o=ADD (don't-care).
- FSM states:
  - IDLE: on valid_i & M op, capture operand magnitudes and sign flags, clear counter.
    - Divisor 0 → DONE.
    - Signed DIV/REM with rs1=MIN and rs2=−1 → DONE.
    - Otherwise → BUSY.
  - BUSY: one radix-2 step per cycle; counter ($clog2(XLEN)+1 bits) counts 0..XLEN−1. At XLEN−1, apply sign correction → DONE.
  - DONE: mdu_done_o=1, result held → IDLE next cycle.
- Arithmetic:
  - Product is 2·XLEN bits. MUL takes the low half; MULH/MULHSU/MULHU take the high half.
  - Signed cases negate the product when operand signs differ. Remainder sign follows the dividend.
- Special results:
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Overflow: quotient = MIN, remainder 0.
- stall_o = valid_i & use_mdu_o & ~mdu_done_o.
- Abort: valid_i low in BUSY → IDLE next cycle; no done pulse; result register unchanged.
- Back-to-back M ops: the second starts in the cycle after DONE (IDLE).
- ENABLE_M=0: M ops give illegal_o=1, stall_o=0, FSM stays IDLE.

## Timing
- Reset (async): state IDLE, counter 0, mdu_result_o 0, mdu_done_o 0. Combinational outputs follow inputs.
- Normal M op:
  - Cycle 0: IDLE accept.
  - Cycles 1..XLEN: BUSY.
  - Cycle XLEN+1: DONE.
  - stall_o is high for XLEN+1 cycles.
- Special-case divide: cycle 0 accept, cycle 1 DONE; stall_o high for 1 cycle.
- Non-M instructions: zero latency, stall_o never asserted.
- Reset mid-operation: immediate IDLE; no done pulse afterwards.

## Structure
- Shared package alu_ctrl_pkg holds:
  - ALU op codes and alu_op_i class codes.
  - M funct3 codes and the M funct7 constant.
  - The FSM state type (IDLE/BUSY/DONE).
- Sub-module mdu_iter_core holds the multiply/divide datapath: operand, accumulator and quotient registers, step logic and sign correction.
- The top level keeps the decoder, FSM and stall logic.

## Test plan
- XLEN=32, MUL rs1=7, rs2=0xFFFFFFFD → stall_o high for 33 cycles; mdu_done_o at cycle 33; result 0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000.
- DIV 0x80000000 / 0xFFFFFFFF → done at cycle 1, result 0x80000000. REM same operands → 0.
- DIVU 100/0 → 0xFFFFFFFF. REMU 100/0 → 100. DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF.
- R SUB (funct7 0100000, f3 000) → alu_operation_o=0001, stall_o=0. LUI → 1010. R funct7=0000010 → illegal_o=1.
- Abort and reset:
  - DIVU started, valid_i dropped at cycle 10 → IDLE at cycle 11, no done pulse.
  - reset asserted at cycle 5 → mdu_result_o=0 immediately.
  - The next MUL completes normally.
